// File: rtl/apb3_pkg.sv
// Shared APB3 completer definitions: FSM states, decode error causes, ID register constants.
package apb3_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_ALIGN = 2'd1,
        ERR_RANGE = 2'd2,
        ERR_RO    = 2'd3
    } apb_err_e;

    localparam int unsigned      ID_REG_IDX       = 0;
    localparam logic [DATA_W-1:0] DEFAULT_ID_VALUE = 32'hA9B3_0001;

endpackage

// File: rtl/apb3_addr_decode.sv
// Combinational APB3 address decode: word index plus error cause for a register bank.
module apb3_addr_decode
    import apb3_pkg::*;
#(
    parameter  int unsigned NUM_REGS = 16,
    localparam int unsigned IDX_W    = $clog2(NUM_REGS)
) (
    input  logic [31:0]      paddr_i,
    input  logic             pwrite_i,
    output logic [IDX_W-1:0] idx_o,
    output apb_err_e         err_o
);

    logic [31:0] word_idx_c;

    assign word_idx_c = {2'b00, paddr_i[31:2]};
    assign idx_o      = paddr_i[IDX_W+1:2];

    // Error priority: misalignment, then out-of-range index, then write to the read-only ID register.
    always_comb begin
        err_o = ERR_NONE;
        if (paddr_i[1:0] != 2'b00) begin
            err_o = ERR_ALIGN;
        end else if (word_idx_c >= NUM_REGS) begin
            err_o = ERR_RANGE;
        end else if (pwrite_i && (word_idx_c == ID_REG_IDX)) begin
            err_o = ERR_RO;
        end
    end

endmodule

// File: rtl/apb3_slave_regfile.sv
// APB3 completer exposing a bank of 32-bit control registers; register 0 is a constant ID.
// Optional wait-state counter is built only when APB3_SLV_WAIT_EN is defined; otherwise
// every transfer completes on its first access cycle.
module apb3_slave_regfile
    import apb3_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] ID_VALUE    = DEFAULT_ID_VALUE
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic                     PSELx,
    input  logic                     PENABLE,
    input  logic                     PWRITE,
    input  logic [31:0]              PADDR,
    input  logic [31:0]              PWDATA,
    output logic [31:0]              PRDATA,
    output logic                     PREADY,
    output logic                     PSLVERR,
    output logic [32*NUM_REGS-1:0]   regs_q,
    output logic [NUM_REGS-1:0]      wr_strobe
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    if ((NUM_REGS < 2) || (NUM_REGS > 256) || (WAIT_CYCLES > 15)) begin : g_bad_params
        $error("apb3_slave_regfile: parameter out of legal range");
    end

    apb_state_e          state_q;
    logic [IDX_W-1:0]    idx_q;
    logic                write_q;
    logic [31:0]         wdata_q;
    logic                err_q;
    logic [NUM_REGS-1:0] strobe_q;
    logic [31:0]         reg_mem_q [NUM_REGS];

    logic [IDX_W-1:0]    dec_idx_c;
    apb_err_e            dec_err_c;
    logic                setup_acc_c;
    logic                wait_done_c;
    logic                pready_c;
    logic [31:0]         rd_word_c;

    apb3_addr_decode #(
        .NUM_REGS (NUM_REGS)
    ) u_decode (
        .paddr_i  (PADDR),
        .pwrite_i (PWRITE),
        .idx_o    (dec_idx_c),
        .err_o    (dec_err_c)
    );

    assign setup_acc_c = (state_q == ST_IDLE) && PSELx && !PENABLE;

`ifdef APB3_SLV_WAIT_EN
    logic [3:0] wait_q;

    // Wait-state counter: loaded at setup, counts down through the access phase, cleared on abort.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wait_q <= '0;
        end else if (setup_acc_c) begin
            wait_q <= 4'(WAIT_CYCLES);
        end else if ((state_q == ST_ACCESS) && !PSELx) begin
            wait_q <= '0;
        end else if (wait_q != 4'd0) begin
            wait_q <= wait_q - 4'd1;
        end
    end

    assign wait_done_c = (wait_q == 4'd0);
`else
    assign wait_done_c = 1'b1;
`endif

    // Bus FSM: latch setup phase, complete or abort the access phase, commit legal writes.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            strobe_q <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                reg_mem_q[i] <= '0;
            end
        end else begin
            strobe_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (setup_acc_c) begin
                        idx_q   <= dec_idx_c;
                        write_q <= PWRITE;
                        wdata_q <= PWDATA;
                        err_q   <= (dec_err_c != ERR_NONE);
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!PSELx) begin
                        state_q <= ST_IDLE;
                    end else if (pready_c && PENABLE) begin
                        state_q <= ST_IDLE;
                        if (write_q && !err_q) begin
                            reg_mem_q[idx_q] <= wdata_q;
                            strobe_q[idx_q]  <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Flat register view; slice 0 is the constant ID.
    assign regs_q[31:0] = ID_VALUE;
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_flat
        assign regs_q[32*gi +: 32] = reg_mem_q[gi];
    end

    // Bus responses decoded from registered state only.
    assign rd_word_c = regs_q[{idx_q, 5'd0} +: 32];
    assign pready_c  = (state_q == ST_ACCESS) && wait_done_c;
    assign PREADY    = pready_c;
    assign PSLVERR   = pready_c && err_q;
    assign PRDATA    = (pready_c && !err_q && !write_q) ? rd_word_c : 32'd0;
    assign wr_strobe = strobe_q;

endmodule

// File: tb/tb_apb3_slave_regfile.sv
// Self-checking bench for apb3_slave_regfile: directed scenarios plus randomized transfers
// checked against an array model of the register bank.
module tb_apb3_slave_regfile;

    localparam int unsigned NUM_REGS    = 16;
    localparam int unsigned WAIT_CYCLES = 2;
    localparam logic [31:0] ID_VAL      = 32'hA9B3_0001;
`ifdef APB3_SLV_WAIT_EN
    localparam int unsigned EXP_WAIT = WAIT_CYCLES;
`else
    localparam int unsigned EXP_WAIT = 0;
`endif

    logic                   PCLK;
    logic                   PRESET;
    logic                   PSELx;
    logic                   PENABLE;
    logic                   PWRITE;
    logic [31:0]            PADDR;
    logic [31:0]            PWDATA;
    logic [31:0]            PRDATA;
    logic                   PREADY;
    logic                   PSLVERR;
    logic [32*NUM_REGS-1:0] regs_q;
    logic [NUM_REGS-1:0]    wr_strobe;

    int vectors = 0;
    int fails   = 0;
    logic [31:0] model [NUM_REGS];

    apb3_slave_regfile #(
        .NUM_REGS    (NUM_REGS),
        .WAIT_CYCLES (WAIT_CYCLES),
        .ID_VALUE    (ID_VAL)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .PSELx     (PSELx),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .regs_q    (regs_q),
        .wr_strobe (wr_strobe)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            check($sformatf("%s reg%0d", tag, i), regs_q[32*i +: 32], (i == 0) ? ID_VAL : model[i]);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // One full transfer starting in the current cycle; ends one cycle after completion, bus idle.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int wt,
                        output logic [NUM_REGS-1:0] sb);
        PSELx   = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = w;
        PADDR   = a;
        PWDATA  = d;
        tick();
        PENABLE = 1'b1;
        wt = 0;
        while (PREADY !== 1'b1 && wt < 32) begin
            check("wait PSLVERR", 32'(PSLVERR), 32'd0);
            check("wait PRDATA", PRDATA, 32'd0);
            wt++;
            tick();
        end
        rd = PRDATA;
        er = PSLVERR;
        tick();
        sb      = wr_strobe;
        PSELx   = 1'b0;
        PENABLE = 1'b0;
    endtask

    // Transfer plus checks against the model computed from the address rules.
    task automatic run(input string tag, input logic [31:0] a, input logic w, input logic [31:0] d);
        logic [31:0]         rd;
        logic                er;
        int                  wt;
        logic [NUM_REGS-1:0] sb;
        logic [31:0]         widx;
        logic                ill;
        logic [31:0]         exp_rd;
        logic [NUM_REGS-1:0] exp_sb;
        widx   = {2'b00, a[31:2]};
        ill    = (a[1:0] != 2'b00) || (widx >= NUM_REGS) || (w && (widx == 0));
        exp_rd = 32'd0;
        exp_sb = '0;
        if (!ill && !w) exp_rd = (widx == 0) ? ID_VAL : model[widx];
        if (!ill && w)  exp_sb[widx] = 1'b1;
        xfer(a, w, d, rd, er, wt, sb);
        if (!ill && w) model[widx] = d;
        check({tag, " PSLVERR"}, 32'(er), 32'(ill));
        check({tag, " PRDATA"}, rd, exp_rd);
        check({tag, " waits"}, 32'(wt), 32'(EXP_WAIT));
        check({tag, " wr_strobe"}, 32'(sb), 32'(exp_sb));
    endtask

    initial begin
        int n;
        logic [31:0] a;
        PRESET  = 1'b1;
        PSELx   = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) model[i] = '0;
        repeat (3) @(posedge PCLK);
        #1;
        check("rst PRDATA", PRDATA, 32'd0);
        check("rst PREADY", 32'(PREADY), 32'd0);
        check("rst PSLVERR", 32'(PSLVERR), 32'd0);
        check("rst wr_strobe", 32'(wr_strobe), 32'd0);
        check_regs("rst");
        PRESET = 1'b0;
        tick();

        run("rd id", 32'h0, 1'b0, 32'h0);

        run("wr 0x8", 32'h8, 1'b1, 32'hDEAD_BEEF);
        tick();
        check("strobe one-shot", 32'(wr_strobe), 32'd0);
        check_regs("after wr 0x8");
        run("rd 0x8", 32'h8, 1'b0, 32'h0);

        run("wr 0x3", 32'h3, 1'b1, 32'h1111_1111);
        run("wr 0x40", 32'h40, 1'b1, 32'h2222_2222);
        run("wr 0x0", 32'h0, 1'b1, 32'h3333_3333);
        run("rd 0x40", 32'h40, 1'b0, 32'h0);
        check_regs("after errors");

        // Abort: drop PSELx during the access phase before completion.
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h4; PWDATA = 32'h5555_AAAA;
        tick();
        PENABLE = 1'b1;
        if (EXP_WAIT >= 2) tick();
        PSELx = 1'b0; PENABLE = 1'b0;
        tick();
        check("abort strobe0", 32'(wr_strobe), 32'd0);
        tick();
        check("abort strobe1", 32'(wr_strobe), 32'd0);
        check_regs("after abort");
        run("post-abort wr 0x4", 32'h4, 1'b1, 32'h0BAD_F00D);
        run("post-abort rd 0x4", 32'h4, 1'b0, 32'h0);

        // Back-to-back writes with no idle cycle between them.
        run("b2b wr 0x4", 32'h4, 1'b1, 32'hCAFE_0004);
        run("b2b wr 0x8", 32'h8, 1'b1, 32'hCAFE_0008);
        check_regs("after b2b");

        // PENABLE high while idle is ignored.
        PSELx = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'hC; PWDATA = 32'h7777_7777;
        tick();
        check("viol PREADY0", 32'(PREADY), 32'd0);
        tick();
        check("viol PREADY1", 32'(PREADY), 32'd0);
        check("viol strobe", 32'(wr_strobe), 32'd0);
        PSELx = 1'b0; PENABLE = 1'b0;
        tick();
        check_regs("after viol");

        // Randomized traffic against the model.
        for (int k = 0; k < 80; k++) begin
            a = 32'($urandom_range(0, 19)) << 2;
            if ($urandom_range(0, 7) == 0)  a = a | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) a = a | 32'h1000_0000;
            run($sformatf("rnd%0d", k), a, 1'($urandom_range(0, 1)), $urandom);
            if ($urandom_range(0, 1) == 1) tick();
        end
        check_regs("after random");

        // Reset while the completing cycle is presented.
        run("pre-rst wr 0xC", 32'hC, 1'b1, 32'h1234_5678);
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'hC; PWDATA = 32'h8765_4321;
        tick();
        PENABLE = 1'b1;
        n = 0;
        while (PREADY !== 1'b1 && n < 32) begin
            n++;
            tick();
        end
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0; PSELx = 1'b0; PENABLE = 1'b0;
        for (int i = 0; i < int'(NUM_REGS); i++) model[i] = '0;
        check("midrst PREADY", 32'(PREADY), 32'd0);
        check("midrst strobe", 32'(wr_strobe), 32'd0);
        tick();
        check("midrst strobe next", 32'(wr_strobe), 32'd0);
        check_regs("after midrst");
        run("post-rst rd 0xC", 32'hC, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/apb3_slave_regfile.md
# apb3_slave_regfile

APB3 completer that terminates the bus driven by the team's APB3 master and exposes a bank of 32-bit control registers to downstream logic. It decodes PADDR, inserts a programmable number of wait states, commits writes, returns read data, and flags illegal accesses with PSLVERR. It sits directly downstream of the master on the slave side of the shared APB3 signal interface.

## Interface
- NUM_REGS, 16: register count, including the ID register at index 0; legal range 2..256.
- WAIT_CYCLES, 2: PREADY-low cycles inserted per access phase; legal range 0..15.
- ID_VALUE, 32'hA9B3_0001: constant returned by register 0.

Ports:
- PCLK  in  1  bus clock; all state changes on its rising edge.
- PRESET  in  1  synchronous, active-high reset.
- PSELx  in  1  slave select.
- PENABLE  in  1  access-phase strobe.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  32  byte address.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer completes this cycle.
- PSLVERR  out  1  transfer error; meaningful only while PREADY = 1.
- regs_q  out  32*NUM_REGS  flat register contents; register i occupies bits [32*i+31:32*i]; slice 0 is ID_VALUE.
- wr_strobe  out  NUM_REGS  one-hot, one-cycle pulse on the cycle after a committed write to register i.

## Operation
- FSM states: IDLE, ACCESS.
- IDLE:
  - If PSELx=1 and PENABLE=0 (setup phase), latch PADDR, PWRITE, and PWDATA.
  - Compute the error flag and load wait_cnt = WAIT_CYCLES, then go to ACCESS.
  - PSELx=1 with PENABLE=1 while in IDLE is a protocol violation: ignored, stay IDLE, no output change.
- ACCESS:
  - PREADY = (wait_cnt == 0); wait_cnt decrements each cycle while nonzero.
  - When PREADY=1 and PSELx=PENABLE=1, the transfer completes: commit the write if legal, then go to IDLE.
  - PSELx=0 in ACCESS aborts: go to IDLE, no write, no strobe.
- Index = latched PADDR[31:2].
- Error conditions, decided at setup and registered:
  - PADDR[1:0] != 0.
  - Index >= NUM_REGS.
  - Write to index 0.
- On error:
  - PSLVERR=1 with PREADY.
  - PRDATA=0.
  - No register state changes.
- Legal read: PRDATA = register[index], valid only while PREADY=1; PRDATA=0 at all other times.
- Legal write: register[index] <= latched PWDATA at the completing edge; wr_strobe[index] pulses on the next cycle.
- Back-to-back transfers: a new setup phase in the cycle after completion is accepted normally.

## Timing
- Reset values:
  - State = IDLE, wait_cnt = 0.
  - PRDATA = 0, PREADY = 0, PSLVERR = 0, wr_strobe = 0.
  - Registers 1..NUM_REGS-1 = 0.
- PRESET asserted mid-ACCESS wins over everything: no write commits on that edge.
- Latency: setup at cycle T, first access cycle T+1, PREADY high at T+1+WAIT_CYCLES.
  - Minimum transfer = 2 cycles (WAIT_CYCLES=0).
- PREADY, PSLVERR, and PRDATA are decoded from registered state only, with no combinational path from bus inputs.
- PSLVERR is 0 whenever PREADY=0.

## Configuration
- APB3_SLV_WAIT_EN:
  - Defined: the wait-state counter is built; WAIT_CYCLES behaves as specified.
  - Undefined: the counter is not instantiated, WAIT_CYCLES is ignored, and PREADY=1 in every ACCESS cycle, giving fixed 2-cycle transfers.

## Structure
- Shared package apb3_pkg holds:
  - FSM state enum typedef.
  - Error-cause enum (ERR_NONE, ERR_ALIGN, ERR_RANGE, ERR_RO).
  - ID register index constant (0).
  - Default ID_VALUE.
- Sub-module apb3_addr_decode: combinational decode of PADDR/PWRITE into index and error cause. It is instantiated once and reusable by future APB3 slaves.

## Test plan
- Reset: hold PRESET 3 cycles -> all outputs 0; read reg 0 returns 32'hA9B3_0001 with PREADY at cycle T+3 (WAIT_CYCLES=2).
- Write then read: write 32'hDEAD_BEEF to 0x8, then read 0x8 -> PRDATA=32'hDEAD_BEEF, PSLVERR=0; wr_strobe[2] pulses once; regs_q slice 2 updated.
- Errors:
  - Write to 0x3 -> PSLVERR=1, no state change.
  - Write to 0x40 (NUM_REGS=16) -> PSLVERR=1, no state change.
  - Write to 0x0 -> PSLVERR=1, reg 0 unchanged.
- Abort: drop PSELx in the second wait cycle of a write to 0x4 -> reg 1 unchanged, no wr_strobe, next transfer completes normally.
- Back-to-back writes to 0x4 and 0x8 with no idle cycle -> both commit; each shows PREADY low for exactly WAIT_CYCLES cycles.
- Build without APB3_SLV_WAIT_EN -> PREADY high on the first access cycle of every transfer.
